rr_arbiter_16: RTL

Round-robin arbiter sharing one 4-to-16 select path among 16 requesters. Picks one requester, holds it until release or hold-limit expiry, then rotates priority. The registered 4-bit winner index drives an instance of the existing `decoder_4to16`, whose output, gated by `grant_valid`, forms the one-hot grant bus.

---
 rtl/rr_arbiter_16_pkg.sv | 11 +
 rtl/decoder_4to16.sv | 12 +
 rtl/rr_arbiter_16.sv | 104 ++++++++++
 3 files changed

// File: rtl/rr_arbiter_16_pkg.sv
// Shared constants for the 16-way round-robin arbiter: widths and FSM state encodings.
package rr_arbiter_16_pkg;

   localparam int unsigned NUM_REQ = 16;
   localparam int unsigned IDX_W   = 4;
   localparam int unsigned CNT_W   = 8;

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_GRANT = 1'b1;

endpackage

// File: rtl/decoder_4to16.sv
// Plain 4-to-16 binary decoder; out[k] is set when sel == k.
module decoder_4to16 (
   input  logic [3:0]  sel,
   output logic [15:0] dec
);

   always_comb begin
      dec = '0;
      dec[sel] = 1'b1;
   end

endmodule

// File: rtl/rr_arbiter_16.sv
// Round-robin arbiter over 16 requesters with an optional hold limit per grant.
// The one-hot grant is the registered winner index decoded and gated by grant_valid.
module rr_arbiter_16
   import rr_arbiter_16_pkg::*;
#(
   parameter int unsigned HOLD_MAX = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_REQ-1:0]  req,
   input  logic                done,
   output logic                grant_valid,
   output logic [IDX_W-1:0]    grant_idx,
   output logic [NUM_REQ-1:0]  grant,
   output logic                timeout
);

   localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(HOLD_MAX);
   localparam logic [CNT_W-1:0] CNT_SAT  = '1;

   logic               state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               valid_q, valid_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               release_now;
   logic [NUM_REQ-1:0] dec;

   // First set request at or after ptr, wrapping; lower offsets win.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                input logic [IDX_W-1:0]   p);
      logic [IDX_W-1:0] k;
      rr_pick = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         k = p + IDX_W'(i);
         if (r[k]) rr_pick = k;
      end
   endfunction

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      valid_d     = valid_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      release_now = 1'b0;
      timeout     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (|req) begin
               idx_d   = rr_pick(req, ptr_q);
               valid_d = 1'b1;
               cnt_d   = CNT_W'(1);
               state_d = ST_GRANT;
            end
         end
         ST_GRANT: begin
            // done beats the hold limit, so a coincident done never pulses timeout
            if (done || !req[idx_q]) begin
               release_now = 1'b1;
            end else if (HOLD_MAX != 0 && cnt_q == HOLD_CNT) begin
               release_now = 1'b1;
               timeout     = 1'b1;
            end else if (cnt_q != CNT_SAT) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (release_now) begin
         ptr_d   = idx_q + IDX_W'(1);
         valid_d = 1'b0;
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         valid_q <= 1'b0;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   decoder_4to16 u_dec (
      .sel (idx_q),
      .dec (dec)
   );

   assign grant_valid = valid_q;
   assign grant_idx   = idx_q;
   assign grant       = dec & {NUM_REQ{valid_q}};

endmodule
